// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types, 8N1 frame constants and a clog2 helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    function automatic int clog2(input int value);
        int result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_tick.sv
// ============================================================================
// Module      : uart_rx_tick
// Description : Clock divider producing one oversample tick every DIVISOR cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_tick
    import uart_pkg::*;
#(
    parameter int DIVISOR = 27
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tick
);

    // A one-cycle divider still needs a 1-bit register to stay legal.
    localparam int CNT_W = (clog2(DIVISOR) > 0) ? clog2(DIVISOR) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DIVISOR - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_enable) begin
            count_d = (count_q == C_LAST) ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_tick = i_enable && (count_q == C_LAST);

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module      : uart_rx
// Description : Oversampling 8N1 UART receiver with frame-error and overrun flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       frame_error,
    output logic       overrun,
    output logic       busy
);

    localparam int DIVISOR = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int SAMP_W  = clog2(OVERSAMPLE);
    localparam int BIT_W   = clog2(DATA_BITS);
    localparam logic [SAMP_W-1:0] C_SAMP_HALF = SAMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SAMP_W-1:0] C_SAMP_LAST = SAMP_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  C_BIT_LAST  = BIT_W'(DATA_BITS - 1);

    rx_state_t            state_q, state_d;
    logic                 sync1_q, sync2_q, prev_q;
    logic [SAMP_W-1:0]    samp_q, samp_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [7:0]           rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_error_q, frame_error_d;
    logic                 pending_q, pending_d;
    logic                 overrun_q, overrun_d;
    logic                 w_rx_s, w_fall, w_tick, w_tick_clear, w_tick_en;

    assign w_rx_s    = sync2_q;
    assign w_fall    = prev_q && !w_rx_s;
    assign w_tick_en = (state_q != IDLE);

    uart_rx_tick #(
        .DIVISOR (DIVISOR)
    ) u_tick (
        .clock    (clock),
        .reset    (reset),
        .i_clear  (w_tick_clear),
        .i_enable (w_tick_en),
        .o_tick   (w_tick)
    );

    always_comb begin
        state_d       = state_q;
        samp_d        = samp_q;
        bit_d         = bit_q;
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        frame_error_d = 1'b0;
        w_tick_clear  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (w_fall) begin
                    state_d      = START;
                    samp_d       = '0;
                    w_tick_clear = 1'b1;
                end
            end
            START: begin
                if (w_tick) begin
                    if (samp_q == C_SAMP_HALF) begin
                        samp_d  = '0;
                        bit_d   = '0;
                        state_d = w_rx_s ? IDLE : DATA;
                    end else begin
                        samp_d = samp_q + SAMP_W'(1);
                    end
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (samp_q == C_SAMP_LAST) begin
                        samp_d         = '0;
                        shift_d[bit_q] = w_rx_s;
                        if (bit_q == C_BIT_LAST) begin
                            bit_d   = '0;
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end else begin
                        samp_d = samp_q + SAMP_W'(1);
                    end
                end
            end
            STOP: begin
                // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
                if (w_tick) begin
                    if (samp_q == C_SAMP_LAST) begin
                        samp_d = '0;
                        if (w_rx_s) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            frame_error_d = 1'b1;
                            state_d       = BREAK;
                        end
                    end else begin
                        samp_d = samp_q + SAMP_W'(1);
                    end
                end
            end
            BREAK: begin
                if (w_rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A same-cycle ack and new byte leaves the byte pending without an overrun.
        pending_d = rx_valid_d ? 1'b1 : (rx_ack ? 1'b0 : pending_q);
        overrun_d = rx_ack ? 1'b0 : ((rx_valid_d && pending_q) ? 1'b1 : overrun_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            prev_q        <= 1'b1;
            samp_q        <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_error_q <= 1'b0;
            pending_q     <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= rx;
            sync2_q       <= sync1_q;
            prev_q        <= w_rx_s;
            samp_q        <= samp_d;
            bit_q         <= bit_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_error_q <= frame_error_d;
            pending_q     <= pending_d;
            overrun_q     <= overrun_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_error = frame_error_q;
    assign overrun     = overrun_q;
    assign busy        = (state_q != IDLE);

endmodule

`default_nettype wire
